// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one-word I-side reads and pushes the
// returned words, with their RVFI seed, into the instruction queue.

package fetch_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [1:0]  ixl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_signals_t;

endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h1eceb000,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [31:0]           imem_addr,
  output logic [3:0]            imem_rmask,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_resp,
  output logic [DATA_WIDTH-1:0] iq_wdata,
  output logic                  iq_enqueue,
  input  logic                  iq_full,
  output rvfi_signals_t         enqueue_rvfi,
  input  logic                  redirect_en,
  input  logic [31:0]           redirect_pc
);

  typedef enum logic [1:0] {
    StIssue,
    StWait,
    StHold,
    StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [31:0]           redirect_target;
  logic [31:0]           pc_plus4;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4        = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    iq_enqueue = 1'b0;
    unique case (state_q)
      StIssue: begin
        // Latch the issued address so it stays put even if pc is redirected mid-request.
        addr_d = pc_q;
        if (redirect_en) begin
          pc_d    = redirect_target;
          state_d = StDrain;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_resp && redirect_en) begin
          pc_d    = redirect_target;
          state_d = StIssue;
        end else if (imem_resp && !iq_full) begin
          iq_enqueue = 1'b1;
          pc_d       = pc_plus4;
          state_d    = StIssue;
        end else if (imem_resp) begin
          hold_d  = imem_rdata;
          state_d = StHold;
        end else if (redirect_en) begin
          pc_d    = redirect_target;
          state_d = StDrain;
        end
      end
      StHold: begin
        if (redirect_en) begin
          pc_d    = redirect_target;
          state_d = StIssue;
        end else if (!iq_full) begin
          iq_enqueue = 1'b1;
          pc_d       = pc_plus4;
          state_d    = StIssue;
        end
      end
      StDrain: begin
        // A redirect here is the newest one and wins even alongside the stale response.
        if (redirect_en) begin
          pc_d = redirect_target;
        end
        if (imem_resp) begin
          state_d = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIssue;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  // Reset gates the strobe directly so no read escapes while rst_n is low.
  assign imem_rmask = (rst_n && state_q == StIssue) ? 4'hF : 4'h0;
  assign imem_addr  = ((state_q == StIssue) ? pc_q : addr_q) & 32'hFFFF_FFFC;
  assign iq_wdata   = (state_q == StHold) ? hold_q : imem_rdata;

  always_comb begin
    enqueue_rvfi          = '0;
    enqueue_rvfi.inst     = 32'(iq_wdata);
    enqueue_rvfi.pc_rdata = pc_q;
    enqueue_rvfi.pc_wdata = pc_plus4;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory model plus one task per scenario.

module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   imem_addr;
  logic [3:0]    imem_rmask;
  logic [31:0]   imem_rdata = '0;
  logic          imem_resp = 1'b0;
  logic [31:0]   iq_wdata;
  logic          iq_enqueue;
  logic          iq_full = 1'b0;
  rvfi_signals_t enqueue_rvfi;
  logic          redirect_en = 1'b0;
  logic [31:0]   redirect_pc = '0;

  int checks = 0;
  int failures = 0;

  int unsigned lat = 1;
  int unsigned cyc = 0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } req_t;
  req_t mq[$];
  req_t nr;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .DATA_WIDTH(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .iq_wdata    (iq_wdata),
    .iq_enqueue  (iq_enqueue),
    .iq_full     (iq_full),
    .enqueue_rvfi(enqueue_rvfi),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16]};
  endfunction

  // Memory: requests captured mid-cycle, answered lat cycles later with a one-cycle strobe.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    imem_resp = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp  = 1'b1;
      imem_rdata = mq[0].data;
      void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (imem_rmask == 4'hF) begin
      nr.data = ovr_en ? ovr_data : word(imem_addr);
      nr.due  = cyc + lat;
      mq.push_back(nr);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    redirect_en = 1'b0;
    iq_full = 1'b0;
    ovr_en = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_rmask !== 4'h0) begin
      failures++; $display("FAIL reset_rmask got=%h exp=0", imem_rmask);
    end
    checks++;
    if (iq_enqueue !== 1'b0) begin
      failures++; $display("FAIL reset_enqueue got=%b exp=0", iq_enqueue);
    end
    checks++;
    if (imem_addr !== RST_PC) begin
      failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    rvfi_signals_t e;
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      a = RST_PC + 32'(4 * (i / 2));
      @(negedge clk);
      if (i % 2 == 0) begin
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== a || iq_enqueue !== 1'b0) begin
          failures++;
          $display("FAIL stream_issue c%0d rmask=%h addr=%h enq=%b exp F/%h/0", i, imem_rmask,
                   imem_addr, iq_enqueue, a);
        end
      end else begin
        e = '0; e.inst = word(a); e.pc_rdata = a; e.pc_wdata = a + 32'd4;
        checks++;
        if (iq_enqueue !== 1'b1 || iq_wdata !== word(a) || imem_rmask !== 4'h0) begin
          failures++;
          $display("FAIL stream_enq c%0d enq=%b wdata=%h rmask=%h exp 1/%h/0", i, iq_enqueue,
                   iq_wdata, imem_rmask, word(a));
        end
        checks++;
        if (enqueue_rvfi !== e) begin
          failures++;
          $display("FAIL stream_rvfi c%0d pc_rdata=%h pc_wdata=%h exp %h/%h", i,
                   enqueue_rvfi.pc_rdata, enqueue_rvfi.pc_wdata, a, a + 32'd4);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_full_stall();
    rvfi_signals_t e;
    do_reset();
    lat = 1; ovr_en = 1'b1; ovr_data = 32'h00a00093;
    for (int i = 0; i < 9; i++) begin
      iq_full = (i <= 6);
      if (i == 1) ovr_en = 1'b0;
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== RST_PC) begin
          failures++; $display("FAIL stall_issue rmask=%h addr=%h", imem_rmask, imem_addr);
        end
      end else if (i <= 6) begin
        checks++;
        if (imem_rmask !== 4'h0 || iq_enqueue !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold c%0d rmask=%h enq=%b exp 0/0", i, imem_rmask, iq_enqueue);
        end
      end else if (i == 7) begin
        e = '0; e.inst = 32'h00a00093; e.pc_rdata = RST_PC; e.pc_wdata = RST_PC + 32'd4;
        checks++;
        if (iq_enqueue !== 1'b1 || iq_wdata !== 32'h00a00093 || enqueue_rvfi !== e) begin
          failures++;
          $display("FAIL stall_release enq=%b wdata=%h pc=%h exp 1/00a00093/%h", iq_enqueue,
                   iq_wdata, enqueue_rvfi.pc_rdata, RST_PC);
        end
      end else begin
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== RST_PC + 32'd4 || iq_enqueue !== 1'b0) begin
          failures++;
          $display("FAIL stall_next rmask=%h addr=%h enq=%b exp F/%h/0", imem_rmask, imem_addr,
                   iq_enqueue, RST_PC + 32'd4);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Shared shape for redirect scenarios: redirects driven per cycle, then fetch at tgt.
  task automatic run_redirect(input string name, input int unsigned l, input int r1_cyc,
                              input logic [31:0] r1_pc, input int r2_cyc,
                              input logic [31:0] r2_pc, input int iss_cyc,
                              input logic [31:0] tgt);
    do_reset();
    lat = l;
    redirect_pc = r1_pc;
    for (int i = 0; i <= iss_cyc + int'(l); i++) begin
      redirect_en = (i == r1_cyc) || (i == r2_cyc);
      redirect_pc = (i == r2_cyc) ? r2_pc : r1_pc;
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== RST_PC || iq_enqueue !== 1'b0) begin
          failures++;
          $display("FAIL %s_issue rmask=%h addr=%h enq=%b", name, imem_rmask, imem_addr,
                   iq_enqueue);
        end
      end else if (i < iss_cyc) begin
        checks++;
        if (imem_rmask !== 4'h0 || iq_enqueue !== 1'b0 || imem_addr !== RST_PC) begin
          failures++;
          $display("FAIL %s_stale c%0d rmask=%h enq=%b addr=%h exp 0/0/%h", name, i, imem_rmask,
                   iq_enqueue, imem_addr, RST_PC);
        end
      end else if (i == iss_cyc) begin
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== tgt || iq_enqueue !== 1'b0) begin
          failures++;
          $display("FAIL %s_refetch rmask=%h addr=%h enq=%b exp F/%h/0", name, imem_rmask,
                   imem_addr, iq_enqueue, tgt);
        end
      end else if (i == iss_cyc + int'(l)) begin
        checks++;
        if (iq_enqueue !== 1'b1 || iq_wdata !== word(tgt) || enqueue_rvfi.pc_rdata !== tgt) begin
          failures++;
          $display("FAIL %s_enq enq=%b wdata=%h pc=%h exp 1/%h/%h", name, iq_enqueue, iq_wdata,
                   enqueue_rvfi.pc_rdata, word(tgt), tgt);
        end
      end else begin
        checks++;
        if (iq_enqueue !== 1'b0 || imem_rmask !== 4'h0) begin
          failures++;
          $display("FAIL %s_wait c%0d enq=%b rmask=%h", name, i, iq_enqueue, imem_rmask);
        end
      end
      @(posedge clk);
      #1;
    end
    redirect_en = 1'b0;
  endtask

  task automatic test_redirect_wait();
    run_redirect("rd_wait", 4, 1, 32'h1eceb100, -1, 32'h0, 5, 32'h1eceb100);
  endtask

  task automatic test_redirect_resp();
    run_redirect("rd_resp", 1, 1, 32'h1eceb400, -1, 32'h0, 2, 32'h1eceb400);
  endtask

  task automatic test_redirect_issue();
    // Second redirect lands in DRAIN together with the stale response; low bits are dropped.
    run_redirect("rd_issue", 1, 0, 32'h1eceb600, 1, 32'h1eceb703, 2, 32'h1eceb700);
  endtask

  task automatic test_double_redirect();
    run_redirect("rd_double", 4, 1, 32'h1eceb200, 2, 32'h1eceb300, 5, 32'h1eceb300);
  endtask

  task automatic test_async_reset();
    do_reset();
    lat = 4; ovr_en = 1'b1; ovr_data = 32'hdeadbeef;
    @(negedge clk);
    checks++;
    if (imem_rmask !== 4'hF || imem_addr !== RST_PC) begin
      failures++; $display("FAIL arst_issue rmask=%h addr=%h", imem_rmask, imem_addr);
    end
    @(posedge clk);
    #1;
    ovr_en = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_rmask !== 4'h0 || iq_enqueue !== 1'b0 || imem_addr !== RST_PC) begin
          failures++;
          $display("FAIL arst_immediate rmask=%h enq=%b addr=%h", imem_rmask, iq_enqueue,
                   imem_addr);
        end
      end
      if (i == 4) rst_n = 1'b1;
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== RST_PC || iq_enqueue !== 1'b0) begin
          failures++;
          $display("FAIL arst_restart rmask=%h addr=%h enq=%b exp F/%h/0", imem_rmask, imem_addr,
                   iq_enqueue, RST_PC);
        end
      end else if (i == 8) begin
        checks++;
        if (iq_enqueue !== 1'b1 || iq_wdata !== word(RST_PC) ||
            enqueue_rvfi.pc_rdata !== RST_PC) begin
          failures++;
          $display("FAIL arst_enq enq=%b wdata=%h pc=%h exp 1/%h/%h", iq_enqueue, iq_wdata,
                   enqueue_rvfi.pc_rdata, word(RST_PC), RST_PC);
        end
      end else begin
        checks++;
        if (iq_enqueue !== 1'b0 || imem_rmask !== 4'h0) begin
          failures++;
          $display("FAIL arst_quiet c%0d enq=%b rmask=%h", i, iq_enqueue, imem_rmask);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_stall();
    test_redirect_wait();
    test_redirect_resp();
    test_redirect_issue();
    test_double_redirect();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
